// File: rtl/pll_rst_pkg.sv
// Shared types and defaults for the PLL reset sequencer: FSM state encoding,
// default parameter values and the shared-timer width helper.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_PLLRST = 3'd1,
    S_STABLE = 3'd2,
    S_RELSYS = 3'd3,
    S_RUN    = 3'd4
  } state_e;

  localparam int unsigned DEF_LOCK_SYNC_STAGES   = 2;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT       = 65536;
  localparam int unsigned DEF_PLL_RST_CYCLES     = 16;
  localparam int unsigned DEF_STAGE_GAP          = 8;
  localparam int unsigned DEF_CNT_W              = 8;

  // The timer only ever reaches (count - 1), so $clog2 of the largest count suffices.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// N-stage single-bit synchronizer with asynchronous active-low clear; used for
// the PLL lock input and for other single control bits crossing into clk_i.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; only the last stage is safe to use downstream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Lock-qualified staged reset generator for the PLL-clocked datapath. Runs on the
// board clock, pulses the rPLL RESET on lock timeout and counts lock-loss events.
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int unsigned LOCK_SYNC_STAGES   = DEF_LOCK_SYNC_STAGES,
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int unsigned PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int unsigned STAGE_GAP          = DEF_STAGE_GAP,
  parameter int unsigned CNT_W              = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             lock,
  output logic             pll_reset,
  output logic             sys_reset_n,
  output logic             dsp_reset_n,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int unsigned TW = timer_width(LOCK_STABLE_CYCLES, LOCK_TIMEOUT,
                                           PLL_RST_CYCLES, STAGE_GAP);

  localparam logic [TW-1:0] T_ONE      = TW'(1'b1);
  localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] PR_LAST    = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] STAB_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             lock_s;
  state_e           state_q;
  logic [TW-1:0]    timer_q;
  logic             pll_reset_q;
  logic             sys_reset_n_q;
  logic             dsp_reset_n_q;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  bit_sync #(
    .STAGES(LOCK_SYNC_STAGES)
  ) u_lock_sync (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (lock),
    .q_o   (lock_s)
  );

  // Saturating lock-loss increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Sequencer FSM; every transition clears the shared timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_WAIT;
      timer_q       <= '0;
      pll_reset_q   <= 1'b0;
      sys_reset_n_q <= 1'b0;
      dsp_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (lock_s) begin
            state_q <= S_STABLE;
            timer_q <= '0;
          end else if (timer_q == TO_LAST) begin
            state_q     <= S_PLLRST;
            timer_q     <= '0;
            pll_reset_q <= 1'b1;
          end else begin
            timer_q <= timer_q + T_ONE;
          end
        end
        S_PLLRST: begin
          if (timer_q == PR_LAST) begin
            state_q     <= S_WAIT;
            timer_q     <= '0;
            pll_reset_q <= 1'b0;
          end else begin
            timer_q <= timer_q + T_ONE;
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_q <= S_WAIT;
            timer_q <= '0;
          end else if (timer_q == STAB_LAST) begin
            state_q       <= S_RELSYS;
            timer_q       <= '0;
            sys_reset_n_q <= 1'b1;
          end else begin
            timer_q <= timer_q + T_ONE;
          end
        end
        S_RELSYS: begin
          if (!lock_s) begin
            state_q       <= S_WAIT;
            timer_q       <= '0;
            sys_reset_n_q <= 1'b0;
            dsp_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            cnt_q         <= cnt_d;
          end else if (timer_q == GAP_LAST) begin
            state_q       <= S_RUN;
            timer_q       <= '0;
            dsp_reset_n_q <= 1'b1;
            ready_q       <= 1'b1;
          end else begin
            timer_q <= timer_q + T_ONE;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_q       <= S_WAIT;
            timer_q       <= '0;
            sys_reset_n_q <= 1'b0;
            dsp_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            cnt_q         <= cnt_d;
          end else begin
            state_q <= S_RUN;
          end
        end
        default: begin
          state_q       <= S_WAIT;
          timer_q       <= '0;
          pll_reset_q   <= 1'b0;
          sys_reset_n_q <= 1'b0;
          dsp_reset_n_q <= 1'b0;
          ready_q       <= 1'b0;
        end
      endcase
    end
  end

  assign pll_reset     = pll_reset_q;
  assign sys_reset_n   = sys_reset_n_q;
  assign dsp_reset_n   = dsp_reset_n_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small parameters: table vectors of
// {reset_n, lock, edges to run, expected outputs} plus hand-written async-reset and saturation runs.
module tb_pll_reset_sequencer;

  localparam int unsigned SYNC    = 2;
  localparam int unsigned STABLE  = 8;
  localparam int unsigned TIMEOUT = 32;
  localparam int unsigned PLLRST  = 4;
  localparam int unsigned GAP     = 3;
  localparam int unsigned CW      = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          lock;
  logic          pll_reset;
  logic          sys_reset_n;
  logic          dsp_reset_n;
  logic          ready;
  logic [CW-1:0] lock_loss_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string name;
    bit    rst_n;
    bit    lk;
    int    edges;
    bit    pll;
    bit    sys;
    bit    dsp;
    bit    rdy;
    int    cnt;
  } vec_t;

  vec_t vecs[$];

  pll_reset_sequencer #(
    .LOCK_SYNC_STAGES  (SYNC),
    .LOCK_STABLE_CYCLES(STABLE),
    .LOCK_TIMEOUT      (TIMEOUT),
    .PLL_RST_CYCLES    (PLLRST),
    .STAGE_GAP         (GAP),
    .CNT_W             (CW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .lock         (lock),
    .pll_reset    (pll_reset),
    .sys_reset_n  (sys_reset_n),
    .dsp_reset_n  (dsp_reset_n),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  function automatic void add(string nm, bit r, bit l, int e, bit p, bit s, bit d, bit y, int c);
    vec_t v;
    v.name = nm; v.rst_n = r; v.lk = l; v.edges = e;
    v.pll = p; v.sys = s; v.dsp = d; v.rdy = y; v.cnt = c;
    vecs.push_back(v);
  endfunction

  task automatic check(string nm, bit p, bit s, bit d, bit y, int c);
    n_vec++;
    if ({pll_reset, sys_reset_n, dsp_reset_n, ready} !== {p, s, d, y} ||
        lock_loss_cnt !== CW'(c)) begin
      n_err++;
      $display("FAIL %s: got pll=%0b sys=%0b dsp=%0b rdy=%0b cnt=%0d, want pll=%0b sys=%0b dsp=%0b rdy=%0b cnt=%0d",
               nm, pll_reset, sys_reset_n, dsp_reset_n, ready, lock_loss_cnt, p, s, d, y, c);
    end
  endtask

  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      reset_n = vecs[i].rst_n;
      lock    = vecs[i].lk;
      edges(vecs[i].edges);
      check(vecs[i].name, vecs[i].pll, vecs[i].sys, vecs[i].dsp, vecs[i].rdy, vecs[i].cnt);
    end
    vecs.delete();
  endtask

  initial begin
    int k;
    reset_n = 1'b0;
    lock    = 1'b0;
    #3;
    check("reset_state_async", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Power-up with lock held, then a one-cycle lock drop from S_RUN and re-release.
    add("reset_held",        1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b0, 1'b0, 0);
    add("lock_edge10",       1'b1, 1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add("sys_rel_edge11",    1'b1, 1'b1, 1,  1'b0, 1'b1, 1'b0, 1'b0, 0);
    add("gap_edge13",        1'b1, 1'b1, 2,  1'b0, 1'b1, 1'b0, 1'b0, 0);
    add("dsp_rel_edge14",    1'b1, 1'b1, 1,  1'b0, 1'b1, 1'b1, 1'b1, 0);
    add("run_hold",          1'b1, 1'b1, 5,  1'b0, 1'b1, 1'b1, 1'b1, 0);
    add("drop_edge1",        1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b1, 1'b1, 0);
    add("drop_edge2",        1'b1, 1'b1, 1,  1'b0, 1'b1, 1'b1, 1'b1, 0);
    add("drop_edge3_loss",   1'b1, 1'b1, 1,  1'b0, 1'b0, 1'b0, 1'b0, 1);
    add("rerel_edge11_pre",  1'b1, 1'b1, 8,  1'b0, 1'b0, 1'b0, 1'b0, 1);
    add("rerel_sys",         1'b1, 1'b1, 1,  1'b0, 1'b1, 1'b0, 1'b0, 1);
    add("rerel_gap",         1'b1, 1'b1, 2,  1'b0, 1'b1, 1'b0, 1'b0, 1);
    add("rerel_dsp",         1'b1, 1'b1, 1,  1'b0, 1'b1, 1'b1, 1'b1, 1);
    // Short lock pulse: no release, and the wait timer restarts on return to S_WAIT.
    add("pulse_reset",       1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 0);
    add("pulse_high5",       1'b1, 1'b1, 5,  1'b0, 1'b0, 1'b0, 1'b0, 0);
    add("pulse_low_e25",     1'b1, 1'b0, 20, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add("pulse_low_e39",     1'b1, 1'b0, 14, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add("pulse_pll_e40",     1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1'b0, 0);
    add("pulse_pll_e43",     1'b1, 1'b0, 3,  1'b1, 1'b0, 1'b0, 1'b0, 0);
    add("pulse_pll_end_e44", 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 0);
    add("pll_period_e75",    1'b1, 1'b0, 31, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add("pll_period_e76",    1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1'b0, 0);
    // Lock arriving on the timeout cycle wins over the PLL reset.
    add("tie_reset",         1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 0);
    add("tie_low29",         1'b1, 1'b0, 29, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add("tie_edge32_nopll",  1'b1, 1'b1, 3,  1'b0, 1'b0, 1'b0, 1'b0, 0);
    add("tie_edge39",        1'b1, 1'b1, 7,  1'b0, 1'b0, 1'b0, 1'b0, 0);
    add("tie_sys_edge40",    1'b1, 1'b1, 1,  1'b0, 1'b1, 1'b0, 1'b0, 0);
    run_table();

    // Async reset in the middle of a pll_reset pulse.
    reset_n = 1'b0; lock = 1'b0;
    edges(1);
    reset_n = 1'b1;
    edges(31);
    check("nolock_e31", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    edges(1);
    check("nolock_pll_e32", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    edges(1);
    #2 reset_n = 1'b0;
    #1 check("async_rst_mid_pulse", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    edges(2);
    reset_n = 1'b1;
    edges(31);
    check("resume_e31", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    edges(1);
    check("resume_pll_e32", 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Async reset while in S_RELSYS, then a full clean sequence.
    reset_n = 1'b0;
    edges(1);
    reset_n = 1'b1; lock = 1'b1;
    edges(12);
    check("relsys_e12", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    #2 reset_n = 1'b0;
    #1 check("async_rst_relsys", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    edges(2);
    reset_n = 1'b1;
    edges(10);
    check("after_rst_e10", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    edges(1);
    check("after_rst_sys_e11", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    edges(3);
    check("after_rst_dsp_e14", 1'b0, 1'b1, 1'b1, 1'b1, 0);

    // 300 lock-loss events from S_RELSYS: counter saturates at 255.
    reset_n = 1'b0;
    edges(1);
    reset_n = 1'b1; lock = 1'b1;
    for (int i = 0; i < 300; i++) begin
      k = 0;
      while (sys_reset_n !== 1'b1 && k < 40) begin
        edges(1);
        k++;
      end
      if (k >= 40) begin
        n_vec++;
        n_err++;
        $display("FAIL sat_wait_release: sys_reset_n=%0b after %0d edges, want 1 (event %0d)",
                 sys_reset_n, k, i);
        break;
      end
      lock = 1'b0;
      edges(3);
      lock = 1'b1;
      if (i == 0)   check("sat_first_loss", 1'b0, 1'b0, 1'b0, 1'b0, 1);
      if (i == 253) check("sat_254", 1'b0, 1'b0, 1'b0, 1'b0, 254);
      if (i == 254) check("sat_255", 1'b0, 1'b0, 1'b0, 1'b0, 255);
    end
    check("sat_after_300", 1'b0, 1'b0, 1'b0, 1'b0, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
